// File: rtl/sort_stream.sv
`default_nettype none
// ============================================================================
// Module      : sort_stream
// Description : Frame sorter for a stream of 8 elements. It loads 8 elements
//               serially, sorts them in 8 odd-even transposition phases (one
//               phase per cycle), then drains them serially in sorted order.
// Ports       : clk, rst                   - clock, synchronous active-high reset
//               in_valid/in_ready/in_data  - input stream (LOAD state only)
//               out_valid/out_ready/
//               out_data/out_last          - sorted output stream (DRAIN state)
//               busy                       - high in SORT and DRAIN
// Parameters  : DATA_W  - element width in bits
//               DESCEND - 0 gives ascending order, 1 gives descending order
// Revision    : 1.0 - initial release
// ============================================================================
module sort_stream #(
    parameter int DATA_W  = 8,
    parameter int DESCEND = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam logic [1:0] c_st_load  = 2'd0;
    localparam logic [1:0] c_st_sort  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [2:0] c_last_idx = 3'd7;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [2:0]        r_wr_cnt;
    logic [2:0]        r_rd_cnt;
    logic [2:0]        r_phase;
    logic [DATA_W-1:0] r_mem    [0:7];
    logic [DATA_W-1:0] w_even   [0:7];
    logic [DATA_W-1:0] w_odd    [0:7];
    logic [DATA_W-1:0] w_sorted [0:7];

    // True when the lower-slot element must move up: strict comparison so
    // equal elements are never exchanged.
    function automatic logic f_swap(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
        if (DESCEND != 0) return (a < b);
        else              return (a > b);
    endfunction

    // Even phase: pairs (0,1) (2,3) (4,5) (6,7).
    for (genvar gi = 0; gi < 4; gi++) begin : g_even
        logic w_sw;
        assign w_sw            = f_swap(r_mem[2*gi], r_mem[2*gi+1]);
        assign w_even[2*gi]    = w_sw ? r_mem[2*gi+1] : r_mem[2*gi];
        assign w_even[2*gi+1]  = w_sw ? r_mem[2*gi]   : r_mem[2*gi+1];
    end

    // Odd phase: pairs (1,2) (3,4) (5,6); the end slots pass through.
    for (genvar gi = 0; gi < 3; gi++) begin : g_odd
        logic w_sw;
        assign w_sw            = f_swap(r_mem[2*gi+1], r_mem[2*gi+2]);
        assign w_odd[2*gi+1]   = w_sw ? r_mem[2*gi+2] : r_mem[2*gi+1];
        assign w_odd[2*gi+2]   = w_sw ? r_mem[2*gi+1] : r_mem[2*gi+2];
    end
    assign w_odd[0] = r_mem[0];
    assign w_odd[7] = r_mem[7];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_sorted[i] = r_phase[0] ? w_odd[i] : w_even[i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_load;
        else     r_state <= w_next_state;
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            c_st_load: begin
                in_ready = 1'b1;
                if (in_valid && (r_wr_cnt == c_last_idx)) w_next_state = c_st_sort;
            end
            c_st_sort: begin
                busy = 1'b1;
                if (r_phase == c_last_idx) w_next_state = c_st_drain;
            end
            c_st_drain: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_mem[r_rd_cnt];
                out_last  = (r_rd_cnt == c_last_idx);
                if (out_ready && (r_rd_cnt == c_last_idx)) w_next_state = c_st_load;
            end
            default: w_next_state = c_st_load;
        endcase
    end

    // Storage and counters. The 3-bit counters wrap from 7 to 0, which
    // leaves each at 0 when its state is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_phase  <= '0;
            for (int i = 0; i < 8; i++) r_mem[i] <= '0;
        end else begin
            case (r_state)
                c_st_load: begin
                    r_phase  <= '0;
                    r_rd_cnt <= '0;
                    if (in_valid) begin
                        r_mem[r_wr_cnt] <= in_data;
                        r_wr_cnt        <= r_wr_cnt + 3'd1;
                    end
                end
                c_st_sort: begin
                    for (int i = 0; i < 8; i++) r_mem[i] <= w_sorted[i];
                    r_phase  <= r_phase + 3'd1;
                    r_rd_cnt <= '0;
                end
                c_st_drain: begin
                    r_wr_cnt <= '0;
                    if (out_ready) r_rd_cnt <= r_rd_cnt + 3'd1;
                end
                default: begin
                    r_wr_cnt <= '0;
                    r_rd_cnt <= '0;
                    r_phase  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
